clkdiv_bank: RTL and testbench

Parametrised multi-channel clock-enable/divider bank driven from the board oscillator. Generalises the fixed two-output divider to N channels, each with a runtime-programmable half-period, a per-channel toggle (50 % duty) or single-cycle pulse mode, an enable, and glitch-free reconfiguration. A common sync pulse phase-aligns all channels. Outputs feed the scan-mirror, ADC and laser-trigger timing logic.

---
 rtl/clkdiv_pkg.sv | 15 +
 rtl/clkdiv_channel.sv | 87 ++++++++
 rtl/clkdiv_bank.sv | 53 +++++
 tb/tb_clkdiv_bank.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/clkdiv_pkg.sv
// Shared constants for the clkdiv_bank divider bank and its channels.
package clkdiv_pkg;

  localparam logic MODE_TOGGLE = 1'b0;
  localparam logic MODE_PULSE  = 1'b1;

  localparam int unsigned DEFAULT_HP = 4166;
  localparam int unsigned MAX_CH     = 16;

  // Channel-select width; a single-channel bank still carries a 1-bit select.
  function automatic int unsigned ch_sel_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/clkdiv_channel.sv
// One divider channel: counter, active/pending configuration and terminal-count output logic.
module clkdiv_channel
  import clkdiv_pkg::*;
#(
  parameter int unsigned DIV_W      = 16,
  parameter int unsigned DEFAULT_HP = clkdiv_pkg::DEFAULT_HP
) (
  input  logic             clkin,
  input  logic             ncr,
  input  logic             en,
  input  logic             sync,
  input  logic             wr,
  input  logic [DIV_W-1:0] wr_hp,
  input  logic             wr_mode,
  output logic             clk_out,
  output logic             tick,
  output logic             pend
);

  logic [DIV_W-1:0] count, count_nxt;
  logic [DIV_W-1:0] act_hp, act_hp_nxt;
  logic [DIV_W-1:0] pnd_hp, pnd_hp_nxt;
  logic             act_mode, act_mode_nxt;
  logic             pnd_mode, pnd_mode_nxt;
  logic             pend_nxt, clk_nxt, tick_nxt;
  logic             restart_c, terminal_c, apply_c;

  // Next-state: pending config is only adopted on a period boundary, so outputs never runt.
  always_comb begin
    restart_c    = sync || !en;
    terminal_c   = !restart_c && (count == act_hp);
    apply_c      = pend && (restart_c || terminal_c);

    count_nxt    = count + DIV_W'(1);
    clk_nxt      = (act_mode == MODE_TOGGLE) ? clk_out : 1'b0;
    tick_nxt     = terminal_c;
    act_hp_nxt   = act_hp;
    act_mode_nxt = act_mode;
    pnd_hp_nxt   = pnd_hp;
    pnd_mode_nxt = pnd_mode;
    pend_nxt     = pend;

    if (restart_c) begin
      count_nxt = '0;
      clk_nxt   = 1'b0;
    end else if (terminal_c) begin
      count_nxt = '0;
      clk_nxt   = (act_mode == MODE_TOGGLE) ? ~clk_out : 1'b1;
    end

    if (apply_c) begin
      act_hp_nxt   = pnd_hp;
      act_mode_nxt = pnd_mode;
      pend_nxt     = 1'b0;
    end

    // A write racing an application lands after it and stays pending.
    if (wr) begin
      pnd_hp_nxt   = wr_hp;
      pnd_mode_nxt = wr_mode;
      pend_nxt     = 1'b1;
    end
  end

  always_ff @(posedge clkin or negedge ncr) begin
    if (!ncr) begin
      count    <= '0;
      act_hp   <= DIV_W'(DEFAULT_HP);
      pnd_hp   <= DIV_W'(DEFAULT_HP);
      act_mode <= MODE_TOGGLE;
      pnd_mode <= MODE_TOGGLE;
      pend     <= 1'b0;
      clk_out  <= 1'b0;
      tick     <= 1'b0;
    end else begin
      count    <= count_nxt;
      act_hp   <= act_hp_nxt;
      pnd_hp   <= pnd_hp_nxt;
      act_mode <= act_mode_nxt;
      pnd_mode <= pnd_mode_nxt;
      pend     <= pend_nxt;
      clk_out  <= clk_nxt;
      tick     <= tick_nxt;
    end
  end

endmodule

// File: rtl/clkdiv_bank.sv
// N-channel programmable clock divider bank: config write decode and sync fan-out.
module clkdiv_bank
  import clkdiv_pkg::*;
#(
  parameter int unsigned N_CH       = 2,
  parameter int unsigned DIV_W      = 16,
  parameter int unsigned DEFAULT_HP = clkdiv_pkg::DEFAULT_HP,
  parameter int unsigned CH_W       = ch_sel_w(N_CH)
) (
  input  logic             clkin,
  input  logic             ncr,
  input  logic [N_CH-1:0]  en,
  input  logic             sync,
  input  logic             cfg_we,
  input  logic [CH_W-1:0]  cfg_ch,
  input  logic [DIV_W-1:0] cfg_hp,
  input  logic             cfg_mode,
  output logic [N_CH-1:0]  clk_out,
  output logic [N_CH-1:0]  tick,
  output logic [N_CH-1:0]  cfg_pend
);

  if (N_CH < 1 || N_CH > MAX_CH) begin : g_bad_n_ch
    $error("clkdiv_bank: N_CH out of range");
  end

  logic ch_ok_c;

  // Writes to channel numbers beyond the bank are dropped.
  assign ch_ok_c = cfg_we && (32'(cfg_ch) < N_CH);

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic wr_c;
    assign wr_c = ch_ok_c && (cfg_ch == CH_W'(i));

    clkdiv_channel #(
      .DIV_W      (DIV_W),
      .DEFAULT_HP (DEFAULT_HP)
    ) u_ch (
      .clkin   (clkin),
      .ncr     (ncr),
      .en      (en[i]),
      .sync    (sync),
      .wr      (wr_c),
      .wr_hp   (cfg_hp),
      .wr_mode (cfg_mode),
      .clk_out (clk_out[i]),
      .tick    (tick[i]),
      .pend    (cfg_pend[i])
    );
  end

endmodule

// File: tb/tb_clkdiv_bank.sv
// Directed bench for clkdiv_bank: defaults, reprogramming, modes, sync, write races and reset.
module tb_clkdiv_bank;
  import clkdiv_pkg::*;

  localparam int unsigned N_CH  = 3;
  localparam int unsigned DIV_W = 16;
  localparam int unsigned CH_W  = 2;

  logic             clkin = 1'b0;
  logic             ncr;
  logic [N_CH-1:0]  en;
  logic             sync;
  logic             cfg_we;
  logic [CH_W-1:0]  cfg_ch;
  logic [DIV_W-1:0] cfg_hp;
  logic             cfg_mode;
  logic [N_CH-1:0]  clk_out;
  logic [N_CH-1:0]  tick;
  logic [N_CH-1:0]  cfg_pend;

  int n_vec = 0;
  int n_err = 0;
  int w, ones_c, ones_t, toggles;
  int f0, f1, both, r0, r1;
  logic prev;
  logic [N_CH-1:0] pc;

  clkdiv_bank #(.N_CH(N_CH), .DIV_W(DIV_W)) dut (
    .clkin    (clkin),
    .ncr      (ncr),
    .en       (en),
    .sync     (sync),
    .cfg_we   (cfg_we),
    .cfg_ch   (cfg_ch),
    .cfg_hp   (cfg_hp),
    .cfg_mode (cfg_mode),
    .clk_out  (clk_out),
    .tick     (tick),
    .cfg_pend (cfg_pend)
  );

  always #5 clkin = ~clkin;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Cycles until tick[ch] is seen; bounded so a dead channel still reaches the summary.
  task automatic wait_tick(input int ch, output int n);
    n = 0;
    do begin
      @(negedge clkin);
      n++;
    end while (tick[ch] !== 1'b1 && n < 10000);
  endtask

  task automatic cfg_write(input logic [CH_W-1:0] ch, input logic [DIV_W-1:0] hp, input logic mode);
    cfg_we   = 1'b1;
    cfg_ch   = ch;
    cfg_hp   = hp;
    cfg_mode = mode;
    @(negedge clkin);
    cfg_we   = 1'b0;
  endtask

  // Reprogram channel 0 by parking it disabled, which applies the write at once.
  task automatic reprog0(input logic [DIV_W-1:0] hp, input logic mode);
    en[0] = 1'b0;
    cfg_write(2'd0, hp, mode);
    @(negedge clkin);
    en[0] = 1'b1;
  endtask

  initial begin
    ncr = 1'b0; en = '0; sync = 1'b0;
    cfg_we = 1'b0; cfg_ch = '0; cfg_hp = '0; cfg_mode = MODE_TOGGLE;
    repeat (3) @(negedge clkin);
    check("rst_clk_out", 32'(clk_out), 32'd0);
    check("rst_tick", 32'(tick), 32'd0);
    check("rst_pend", 32'(cfg_pend), 32'd0);

    // Defaults: 4167-cycle half period on ch0/ch1
    ncr = 1'b1; en = 3'b011;
    wait_tick(0, w);
    check("dflt_first_tick", 32'(w), 32'd4167);
    check("dflt_tick_both", 32'(tick), 32'b011);
    check("dflt_clk_hi", 32'(clk_out), 32'b011);
    check("dflt_pend", 32'(cfg_pend), 32'd0);
    @(negedge clkin);
    check("dflt_tick_1cyc", 32'(tick), 32'd0);
    wait_tick(0, w);
    check("dflt_period", 32'(w), 32'd4166);
    check("dflt_clk_lo", 32'(clk_out), 32'd0);

    // ch1 hp=3 written mid-period: waits for terminal, then period 8
    repeat (100) @(negedge clkin);
    cfg_write(2'd1, 16'd3, MODE_TOGGLE);
    check("wr_pend_set", 32'(cfg_pend), 32'b010);
    wait_tick(1, w);
    check("wr_old_period_done", 32'(w), 32'd4066);
    check("wr_pend_clr", 32'(cfg_pend), 32'd0);
    check("wr_clk1_hi", 32'(clk_out[1]), 32'd1);
    wait_tick(1, w);
    check("hp3_half_a", 32'(w), 32'd4);
    check("hp3_clk_lo", 32'(clk_out[1]), 32'd0);
    wait_tick(1, w);
    check("hp3_half_b", 32'(w), 32'd4);
    check("hp3_clk_hi", 32'(clk_out[1]), 32'd1);
    wait_tick(0, w);
    check("ch0_unaffected", 32'(w), 32'd4159);
    check("ch0_clk_lo", 32'(clk_out[0]), 32'd0);

    // ch0 pulse mode hp=4: one high cycle in five
    reprog0(16'd4, MODE_PULSE);
    check("pulse_pend_clr", 32'(cfg_pend), 32'd0);
    wait_tick(0, w);
    check("pulse_first", 32'(w), 32'd5);
    check("pulse_hi", 32'(clk_out[0]), 32'd1);
    ones_c = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clkin);
      ones_c += int'(clk_out[0]);
    end
    check("pulse_duty", 32'(ones_c), 32'd2);

    // hp=0 pulse: constant high
    reprog0(16'd0, MODE_PULSE);
    @(negedge clkin);
    ones_c = 0; ones_t = 0;
    for (int i = 0; i < 8; i++) begin
      ones_c += int'(clk_out[0]);
      ones_t += int'(tick[0]);
      @(negedge clkin);
    end
    check("hp0_pulse_clk", 32'(ones_c), 32'd8);
    check("hp0_pulse_tick", 32'(ones_t), 32'd8);

    // hp=0 toggle: clkin/2
    reprog0(16'd0, MODE_TOGGLE);
    @(negedge clkin);
    prev = clk_out[0];
    check("hp0_tog_first", 32'(prev), 32'd1);
    toggles = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clkin);
      if (clk_out[0] != prev) toggles++;
      prev = clk_out[0];
    end
    check("hp0_tog_rate", 32'(toggles), 32'd8);

    en[0] = 1'b0;
    @(negedge clkin);
    check("dis_outputs", 32'({clk_out[0], tick[0]}), 32'd0);

    // hp 5 and 10, then sync aligns them
    cfg_write(2'd0, 16'd5, MODE_TOGGLE);
    cfg_write(2'd1, 16'd10, MODE_TOGGLE);
    en = 3'b011;
    repeat (30) @(negedge clkin);
    sync = 1'b1;
    @(negedge clkin);
    sync = 1'b0;
    check("sync_clk", 32'(clk_out), 32'd0);
    check("sync_tick", 32'(tick), 32'd0);
    check("sync_pend", 32'(cfg_pend), 32'd0);
    f0 = 0; f1 = 0; both = 0; r0 = 0; r1 = 0; pc = clk_out;
    for (int t = 1; t <= 70; t++) begin
      @(negedge clkin);
      if (tick[0] && f0 == 0) f0 = t;
      if (tick[1] && f1 == 0) f1 = t;
      if (tick[1:0] == 2'b11 && both == 0) both = t;
      if (clk_out[0] && !pc[0]) r0++;
      if (clk_out[1] && !pc[1]) r1++;
      pc = clk_out;
    end
    check("sync_first0", 32'(f0), 32'd6);
    check("sync_first1", 32'(f1), 32'd11);
    check("sync_coincide", 32'(both), 32'd66);
    check("sync_rises0", 32'(r0), 32'd6);
    check("sync_rises1", 32'(r1), 32'd3);

    // Write B on the cycle A is applied (ch1 terminal at t=77)
    cfg_write(2'd1, 16'd2, MODE_TOGGLE);
    repeat (5) @(negedge clkin);
    cfg_write(2'd1, 16'd7, MODE_TOGGLE);
    check("race_tick", 32'(tick[1]), 32'd1);
    check("race_pend_kept", 32'(cfg_pend), 32'b010);
    wait_tick(1, w);
    check("race_old_applied", 32'(w), 32'd3);
    check("race_pend_clr", 32'(cfg_pend), 32'd0);
    wait_tick(1, w);
    check("race_new_applied", 32'(w), 32'd8);

    cfg_write(2'd3, 16'd1, MODE_PULSE);
    check("oob_ignored", 32'(cfg_pend), 32'd0);
    wait_tick(1, w);
    check("oob_hp_kept", 32'(w), 32'd7);

    // Async reset with a pending write discards it
    cfg_write(2'd0, 16'd9, MODE_TOGGLE);
    check("rst_pend_before", 32'(cfg_pend), 32'b001);
    #2 ncr = 1'b0;
    #1;
    check("arst_clk", 32'(clk_out), 32'd0);
    check("arst_tick", 32'(tick), 32'd0);
    check("arst_pend", 32'(cfg_pend), 32'd0);
    repeat (3) @(negedge clkin);
    ncr = 1'b1;
    wait_tick(0, w);
    check("post_rst_dflt", 32'(w), 32'd4167);
    check("post_rst_tick", 32'(tick), 32'b011);
    check("post_rst_clk", 32'(clk_out), 32'b011);
    check("post_rst_pend", 32'(cfg_pend), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
